// File: rtl/counter_pkg.sv
// Shared definitions for the counting primitives: the control-FSM state type
// and helpers for the terminal value and load clamping that the timer blocks
// will also use.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } cnt_state_t;

    // Terminal value for a modulo counter: top of range counting up, zero counting down.
    function automatic int unsigned termValue(input logic up, input int unsigned modulus);
        return up ? (modulus - 1) : 0;
    endfunction

    // Saturate a load value into the legal count range 0..modulus-1.
    function automatic int unsigned clampLoad(input int unsigned value, input int unsigned modulus);
        return (value > (modulus - 1)) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/sync_counter_fsm.sv
// Control FSM for the modulo counter: decides between idling, running and the
// halted state a one-shot count parks in after reaching its terminal value.
import counter_pkg::*;

module sync_counter_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       oneshot,
    input  logic       en,
    input  logic       tc,
    input  logic       load,
    output cnt_state_t o_state,
    output logic       o_done
);

    cnt_state_t r_state;
    logic       r_done;

    // State register with a registered done flag that mirrors the HALT state;
    // a load in RUN takes priority over the terminal-count halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (en && tc && oneshot && !load) begin
                        r_state <= HALT;
                        r_done  <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_state <= RUN;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_done  = r_done;

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-MOD up/down counter with enable, clamped parallel load,
// terminal-count flag and a one-shot/free-run control FSM. All count bits
// update on the same clock edge; wrap is by explicit compare so any MOD works.
import counter_pkg::*;

module sync_mod_counter #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         start,
    input  logic         oneshot,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         done
);

    if ((MOD < 2) || (MOD > (1 << N))) begin : gBadMod
        $error("sync_mod_counter: MOD must lie in 2..2**N");
    end

    localparam logic [N-1:0] MaxCount = N'(MOD - 1);

    logic [N-1:0] r_q;
    logic [N-1:0] w_terminal;
    logic [N-1:0] w_loadVal;
    logic [N-1:0] w_stepVal;
    logic         w_atTerm;
    logic         w_tc;
    cnt_state_t   w_state;

    assign w_terminal = N'(termValue(up, MOD));
    assign w_loadVal  = N'(clampLoad(int'(d), MOD));
    assign w_atTerm   = (r_q == w_terminal);
    assign w_tc       = (w_state == RUN) && en && w_atTerm;

    // Next value for an enabled count: wrap at the terminal value in free-run,
    // park on it in one-shot mode.
    always_comb begin
        w_stepVal = r_q;
        if (w_atTerm) begin
            if (!oneshot) begin
                w_stepVal = up ? '0 : MaxCount;
            end
        end else begin
            w_stepVal = up ? (r_q + N'(1)) : (r_q - N'(1));
        end
    end

    // Count register: reset beats load, load beats counting, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_loadVal;
        end else if ((w_state == RUN) && en) begin
            r_q <= w_stepVal;
        end
    end

    sync_counter_fsm uFsm (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .oneshot (oneshot),
        .en      (en),
        .tc      (w_tc),
        .load    (load),
        .o_state (w_state),
        .o_done  (done)
    );

    assign q  = r_q;
    assign tc = w_tc;

endmodule

// File: tb/tb_sync_mod_counter.sv
// Self-checking bench for sync_mod_counter (N=4, MOD=10): directed sequences
// followed by random stimulus, all compared against a behavioural model.
module tb_sync_mod_counter;

    localparam int N   = 4;
    localparam int MOD = 10;

    localparam int StIdle = 0;
    localparam int StRun  = 1;
    localparam int StHalt = 2;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] d;
    logic         start;
    logic         oneshot;
    logic [N-1:0] q;
    logic         tc;
    logic         done;

    int checkCount;
    int passCount;

    int modelQ;
    int modelSt;
    int modelDone;

    sync_mod_counter #(.N(N), .MOD(MOD)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .d       (d),
        .start   (start),
        .oneshot (oneshot),
        .q       (q),
        .tc      (tc),
        .done    (done)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the model and tally the result.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Terminal-count flag as the model sees it for the current inputs.
    function automatic int modelTc();
        int term;
        term = up ? (MOD - 1) : 0;
        return ((modelSt == StRun) && en && (modelQ == term)) ? 1 : 0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic modelStep();
        int nextQ;
        int nextSt;
        int tcNow;
        if (reset) begin
            modelQ    = 0;
            modelSt   = StIdle;
            modelDone = 0;
        end else begin
            tcNow  = modelTc();
            nextQ  = modelQ;
            nextSt = modelSt;
            if (load) begin
                nextQ = (int'(d) > MOD - 1) ? (MOD - 1) : int'(d);
            end else if ((modelSt == StRun) && en) begin
                if (tcNow == 1 && oneshot) nextQ = modelQ;
                else if (up)               nextQ = (modelQ + 1) % MOD;
                else                       nextQ = (modelQ + MOD - 1) % MOD;
            end
            if ((modelSt == StIdle || modelSt == StHalt) && start) nextSt = StRun;
            else if (modelSt == StRun && tcNow == 1 && oneshot && !load) nextSt = StHalt;
            modelQ    = nextQ;
            modelSt   = nextSt;
            modelDone = (nextSt == StHalt) ? 1 : 0;
        end
    endtask

    // Drive one cycle of inputs, check tc before the edge and q/done after it.
    task automatic applyStimulus(input logic iReset, input logic iEn, input logic iUp,
                                 input logic iLoad, input logic [N-1:0] iD,
                                 input logic iStart, input logic iOneshot);
        @(negedge clk);
        reset   = iReset;
        en      = iEn;
        up      = iUp;
        load    = iLoad;
        d       = iD;
        start   = iStart;
        oneshot = iOneshot;
        #1;
        checkOutput("tc", int'(tc), modelTc());
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("q", int'(q), modelQ);
        checkOutput("done", int'(done), modelDone);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset   = 1'b1;
        en      = 1'b0;
        up      = 1'b1;
        load    = 1'b0;
        d       = '0;
        start   = 1'b0;
        oneshot = 1'b0;
        modelQ    = 0;
        modelSt   = StIdle;
        modelDone = 0;
        repeat (2) @(posedge clk);

        // 1: reset, start, then free-run up for 12 cycles
        applyStimulus(1, 0, 1, 0, 4'd0, 0, 0);
        checkOutput("reset_q", int'(q), 0);
        applyStimulus(0, 1, 1, 0, 4'd0, 1, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 4'd0, 0, 0);
        checkOutput("wrap_up_q", int'(q), 2);

        // 2: count down through zero from 2
        applyStimulus(0, 0, 0, 1, 4'd2, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 4'd0, 0, 0);
        checkOutput("wrap_down_q", int'(q), 7);

        // 3: one-shot up from 0, park at 9, then resume
        applyStimulus(0, 0, 1, 1, 4'd0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 4'd0, 0, 1);
        checkOutput("oneshot_park_q", int'(q), 9);
        checkOutput("oneshot_done", int'(done), 1);
        applyStimulus(0, 1, 1, 0, 4'd0, 1, 0);
        applyStimulus(0, 1, 1, 0, 4'd0, 0, 0);
        checkOutput("resume_wrap_q", int'(q), 0);

        // 4: clamped load, then load overriding a count in RUN
        applyStimulus(0, 0, 1, 1, 4'd13, 0, 0);
        checkOutput("clamp_q", int'(q), 9);
        applyStimulus(0, 1, 1, 1, 4'd5, 0, 0);
        checkOutput("load_run_q", int'(q), 5);

        // 5: load plus start from IDLE
        applyStimulus(1, 0, 1, 0, 4'd0, 0, 0);
        applyStimulus(0, 0, 1, 1, 4'd3, 1, 0);
        applyStimulus(0, 1, 1, 0, 4'd0, 0, 0);
        checkOutput("load_start_q", int'(q), 4);

        // 6: reset with load mid-count, then en alone must not count
        applyStimulus(0, 0, 1, 1, 4'd7, 0, 0);
        applyStimulus(1, 1, 1, 1, 4'd2, 0, 0);
        applyStimulus(0, 1, 1, 0, 4'd0, 0, 0);
        applyStimulus(0, 1, 1, 0, 4'd0, 0, 0);
        checkOutput("idle_hold_q", int'(q), 0);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(49) == 0),
                          ($urandom_range(3) != 0),
                          ($urandom_range(1) == 1),
                          ($urandom_range(7) == 0),
                          N'($urandom_range(15)),
                          ($urandom_range(5) == 0),
                          ($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sync_mod_counter.md
# sync_mod_counter

Parametrised synchronous modulo-M up/down counter. It replaces the ripple counter wherever the count must be valid within one clock period, independent of width. Every bit changes on the same `clk` edge. Adds enable, direction, parallel load, a terminal-count flag and a one-shot/free-run control FSM. It is the general counting primitive for timers, dividers and address sequencers in the design.

## Interface
Parameters:
- `N`, 4, counter width in bits.
- `MOD`, 16, modulus; count range is 0..MOD-1. Legal range is 2 ≤ MOD ≤ 2**N; elaboration fails outside it.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; effective only in RUN.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  parallel load strobe.
- `d`  in  N  load value.
- `start`  in  1  moves the FSM to RUN from IDLE or HALT.
- `oneshot`  in  1  1 = stop at terminal count, 0 = wrap (free-run).
- `q`  out  N  registered count.
- `tc`  out  1  terminal-count flag; combinational from registered state and inputs.
- `done`  out  1  registered; high while in HALT.

## Operation
- Terminal value: MOD-1 when `up`=1, 0 when `up`=0.
- FSM states: IDLE, RUN, HALT.
  - IDLE: reset state; `q` holds.
  - RUN: counts when `en`=1.
  - HALT: `q` holds; `done`=1.
- IDLE→RUN and HALT→RUN on `start`.
- RUN→HALT on `en` && `oneshot` && `q`==terminal. `q` stays at the terminal value; it does not wrap.
- RUN with `oneshot`=0 never leaves RUN. When `en` && `q`==terminal, `q` wraps: MOD-1→0 counting up, 0→MOD-1 counting down.
- `start` in RUN has no effect.
- `tc` = (state==RUN) && `en` && (`q`==terminal).
- `q` update priority, highest first:
  - `reset` → `q`=0, state IDLE.
  - `load` → `q`=`d`, or MOD-1 if `d` > MOD-1. Allowed in any state; state unchanged, except that `start` is still honoured in the same cycle.
  - RUN && `en` → ±1 modulo MOD.
  - otherwise hold.
- Load in RUN suppresses that cycle's count and any RUN→HALT transition.
- `up` may change on any cycle; the terminal value follows it immediately.
- Arithmetic is N bits wide, with explicit modulo-MOD compare. No reliance on natural 2**N overflow, so non-power-of-two MOD is exact.

## Timing
- Reset values: `q`=0, `done`=0, `tc`=0 (state IDLE).
- Load latency is 1 cycle: `d` appears on `q` the edge after `load`=1.
- Count latency is 1 cycle per enabled edge.
- `tc` is valid in the same cycle in which `q` equals the terminal value. It is high for exactly one cycle per wrap when `en` is held.
- `done` rises on the edge that performs RUN→HALT, i.e. the cycle after `tc`. It falls on the edge after `start`.
- `start` and `load` in the same cycle both take effect: the next cycle is in RUN with `q`=`d`.
- `reset` during RUN or HALT takes effect on the next edge and overrides `load` and `start`.
- All outputs are glitch-free relative to `clk` except `tc`, which is combinational from `en` and `up`.

## Structure
- Shared package `counter_pkg` holds:
  - the `cnt_state_t` enum {IDLE, RUN, HALT};
  - the constant function for the terminal value and clamp helper, reused by future timer blocks.
- One sub-module is natural: `sync_counter_fsm`. It takes `start`, `oneshot`, `en`, `tc` and `load`, and outputs state and `done`.
- The datapath (next-`q` mux, modulo compare, clamp) stays in the top module.

## Test plan
Bench configuration: N=4, MOD=10.
1. Reset, then `start`, `en`=1, `up`=1, `oneshot`=0 for 12 cycles → `q` = 0,1,…,9,0,1. `tc` is high only while `q`=9. `done` stays 0.
2. `up`=0 from `q`=2, free-run → `q` = 2,1,0,9,8. `tc` is high only while `q`=0.
3. `oneshot`=1, `up`=1, start from 0 → `q` stops at 9. `done`=1 from the cycle after `tc`. Further `en` leaves `q`=9. `start` resumes: `q`=0 next enabled edge (wrap), `done`=0.
4. `load`=1 with `d`=13 → `q`=9 (clamped). `load` with `d`=5 in RUN and `en`=1 → `q`=5, no increment that cycle.
5. `load` with `d`=3 plus `start` in IDLE → next cycle in RUN with `q`=3, then 4.
6. Assert `reset` mid-count at `q`=7 together with `load`=1, `d`=2 → next cycle `q`=0, IDLE, `done`=0, `tc`=0. `en` alone does not count until `start`.
